// File: rtl/udma_l2_responder.sv
// L2 memory endpoint serving the uDMA ro/wo TCDM ports from one shared single-port word array.
// Optional UDMA_L2_RESP_STALL_EN: LFSR-driven grant backpressure (~25% of cycles stalled).
module udma_l2_responder #(
    parameter int unsigned L2_DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_resetn_i,

    input  logic                       L2_ro_req_o,
    input  logic                       L2_ro_wen_o,
    input  logic [31:0]                L2_ro_addr_o,
    input  logic [L2_DATA_WIDTH/8-1:0] L2_ro_be_o,
    input  logic [L2_DATA_WIDTH-1:0]   L2_ro_wdata_o,
    output logic                       L2_ro_gnt_i,
    output logic                       L2_ro_rvalid_i,
    output logic [L2_DATA_WIDTH-1:0]   L2_ro_rdata_i,

    input  logic                       L2_wo_req_o,
    input  logic                       L2_wo_wen_o,
    input  logic [31:0]                L2_wo_addr_o,
    input  logic [L2_DATA_WIDTH/8-1:0] L2_wo_be_o,
    input  logic [L2_DATA_WIDTH-1:0]   L2_wo_wdata_o,
    output logic                       L2_wo_gnt_i,
    output logic                       L2_wo_rvalid_i,
    output logic [L2_DATA_WIDTH-1:0]   L2_wo_rdata_i,

    output logic [31:0]                rd_cnt_o,
    output logic [31:0]                wr_cnt_o,
    output logic                       oob_err_o
);

    localparam int unsigned BE_W   = L2_DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(BE_W);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

    logic [L2_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic                     rr_wo_q;
    logic                     ro_rvalid_q;
    logic                     wo_rvalid_q;
    logic [L2_DATA_WIDTH-1:0] ro_rdata_q;
    logic [L2_DATA_WIDTH-1:0] wo_rdata_q;
    logic [31:0]              rd_cnt_q;
    logic [31:0]              wr_cnt_q;
    logic                     oob_q;

    logic                     stall_c;
    logic                     open_c;
    logic                     conflict_c;
    logic                     win_ro_c;
    logic                     win_wo_c;
    logic                     acc_c;

    logic                     sel_wen_c;
    logic [31:0]              sel_addr_c;
    logic [BE_W-1:0]          sel_be_c;
    logic [L2_DATA_WIDTH-1:0] sel_wdata_c;

    logic [31:0]              off_c;
    logic [31:0]              word_c;
    logic                     oob_c;
    logic [IDX_W-1:0]         idx_c;
    logic [L2_DATA_WIDTH-1:0] resp_data_c;

`ifdef UDMA_L2_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
    always_ff @(posedge sys_clk_i) begin
        if (!sys_resetn_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_c = 1'b0;
`endif

    assign open_c      = sys_resetn_i & ~stall_c;
    assign conflict_c  = L2_ro_req_o & L2_wo_req_o;
    assign win_ro_c    = L2_ro_req_o & (~L2_wo_req_o | ~rr_wo_q);
    assign win_wo_c    = L2_wo_req_o & (~L2_ro_req_o |  rr_wo_q);
    assign L2_ro_gnt_i = win_ro_c & open_c;
    assign L2_wo_gnt_i = win_wo_c & open_c;
    assign acc_c       = L2_ro_gnt_i | L2_wo_gnt_i;

    // Route the granted port onto the single array access path
    always_comb begin
        sel_wen_c   = L2_ro_wen_o;
        sel_addr_c  = L2_ro_addr_o;
        sel_be_c    = L2_ro_be_o;
        sel_wdata_c = L2_ro_wdata_o;
        if (L2_wo_gnt_i) begin
            sel_wen_c   = L2_wo_wen_o;
            sel_addr_c  = L2_wo_addr_o;
            sel_be_c    = L2_wo_be_o;
            sel_wdata_c = L2_wo_wdata_o;
        end
    end

    assign off_c       = sel_addr_c - BASE_ADDR;
    assign word_c      = off_c >> OFFS_W;
    assign oob_c       = (sel_addr_c < BASE_ADDR) || (word_c >= 32'(MEM_WORDS));
    assign idx_c       = word_c[IDX_W-1:0];
    assign resp_data_c = (sel_wen_c && !oob_c) ? mem_q[idx_c] : '0;

    // Array contents are deliberately left unreset
    always_ff @(posedge sys_clk_i) begin
        if (acc_c && !sel_wen_c && !oob_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (sel_be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= sel_wdata_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_resetn_i) begin
            rr_wo_q     <= 1'b0;
            ro_rvalid_q <= 1'b0;
            wo_rvalid_q <= 1'b0;
            ro_rdata_q  <= '0;
            wo_rdata_q  <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            oob_q       <= 1'b0;
        end else begin
            ro_rvalid_q <= L2_ro_gnt_i;
            wo_rvalid_q <= L2_wo_gnt_i;
            if (L2_ro_gnt_i) begin
                ro_rdata_q <= resp_data_c;
            end
            if (L2_wo_gnt_i) begin
                wo_rdata_q <= resp_data_c;
            end
            if (acc_c && sel_wen_c) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (acc_c && !sel_wen_c) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (acc_c && oob_c) begin
                oob_q <= 1'b1;
            end
            // The loser of a conflict wins the next one
            if (conflict_c && open_c) begin
                rr_wo_q <= win_ro_c;
            end
        end
    end

    assign L2_ro_rvalid_i = ro_rvalid_q;
    assign L2_wo_rvalid_i = wo_rvalid_q;
    assign L2_ro_rdata_i  = ro_rdata_q;
    assign L2_wo_rdata_i  = wo_rdata_q;
    assign rd_cnt_o       = rd_cnt_q;
    assign wr_cnt_o       = wr_cnt_q;
    assign oob_err_o      = oob_q;

endmodule
